systolic_pe: RTL and testbench

SYSTOLIC_PE -- requirements
Module: systolic_pe

---
 rtl/npu_pkg.sv | 14 +
 rtl/pe_mac_unit.sv | 35 +++
 rtl/systolic_pe.sv | 136 +++++++++++++
 tb/tb_systolic_pe.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared types and width helpers for the NPU processing-element array.
package npu_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } pe_state_e;

   // Accumulator width: full product width plus headroom for n summed products.
   function automatic int acc_width(input int dw, input int n);
      return 2 * dw + $clog2(n);
   endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// Multiply-extend-add datapath: extends both operands to ACCW, multiplies,
// and adds the product to the running sum (or to zero when starting fresh).
module pe_mac_unit #(
   parameter int DW     = 8,
   parameter int ACCW   = 17,
   parameter bit SIGNED = 1'b0
) (
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   input  logic [ACCW-1:0] acc_in,
   input  logic            restart,
   output logic [ACCW-1:0] sum
);

   logic [ACCW-1:0] a_ext;
   logic [ACCW-1:0] b_ext;
   logic [ACCW-1:0] product;
   logic [ACCW-1:0] base;

   // Truncating the ACCW x ACCW product yields the exact product modulo
   // 2^ACCW for both sign- and zero-extended operands.
   always_comb begin
      if (SIGNED) begin
         a_ext = {{(ACCW-DW){a[DW-1]}}, a};
         b_ext = {{(ACCW-DW){b[DW-1]}}, b};
      end else begin
         a_ext = {{(ACCW-DW){1'b0}}, a};
         b_ext = {{(ACCW-DW){1'b0}}, b};
      end
      product = a_ext * b_ext;
      base    = restart ? '0 : acc_in;
      sum     = base + product;
   end

endmodule

// File: rtl/systolic_pe.sv
// Systolic-array processing element: forwards operands east/south and
// accumulates N products per result with a valid/ready result register.
module systolic_pe
   import npu_pkg::*;
#(
   parameter  int DW     = 8,
   parameter  int N      = 2,
   parameter  bit SIGNED = 1'b0,
   localparam int ACCW   = acc_width(DW, N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [DW-1:0]   a_in,
   input  logic [DW-1:0]   b_in,
   input  logic            clr,
   input  logic            res_ready,
   output logic [DW-1:0]   a_out,
   output logic [DW-1:0]   b_out,
   output logic            v_out,
   output logic [ACCW-1:0] acc_out,
   output logic            res_valid,
   output logic            pdone,
   output logic            ovf
);

   localparam int           CW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   pe_state_e       state_q,     state_d;
   logic [CW-1:0]   count_q,     count_d;
   logic [ACCW-1:0] acc_q,       acc_d;
   logic [DW-1:0]   a_out_q,     a_out_d;
   logic [DW-1:0]   b_out_q,     b_out_d;
   logic            v_out_q,     v_out_d;
   logic [ACCW-1:0] acc_out_q,   acc_out_d;
   logic            res_valid_q, res_valid_d;
   logic            pdone_q,     pdone_d;
   logic            ovf_q,       ovf_d;

   logic [CW-1:0]   eff_count;
   logic            restart;
   logic            done;
   logic [ACCW-1:0] mac_sum;

   pe_mac_unit #(
      .DW     (DW),
      .ACCW   (ACCW),
      .SIGNED (SIGNED)
   ) u_mac (
      .a       (a_in),
      .b       (b_in),
      .acc_in  (acc_q),
      .restart (restart),
      .sum     (mac_sum)
   );

   // NOTE: every signal assigned here gets a default first so no path can
   // leave it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      acc_d     = acc_q;
      done      = 1'b0;

      // clr discards the partial sum; a beat in the same cycle starts anew.
      restart   = clr || (state_q == ST_IDLE);
      eff_count = clr ? '0 : count_q;

      if (clr) begin
         state_d = ST_IDLE;
         count_d = '0;
         acc_d   = '0;
      end

      if (in_valid) begin
         if (eff_count == LAST) begin
            done    = 1'b1;
            state_d = ST_IDLE;
            count_d = '0;
            acc_d   = '0;
         end else begin
            state_d = ST_ACC;
            count_d = eff_count + 1'b1;
            acc_d   = mac_sum;
         end
      end
   end

   always_comb begin
      a_out_d     = a_in;
      b_out_d     = b_in;
      v_out_d     = in_valid;
      pdone_d     = done;
      acc_out_d   = done ? mac_sum : acc_out_q;
      res_valid_d = done | (res_valid_q & ~res_ready);
      ovf_d       = ovf_q | (done & res_valid_q & ~res_ready);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         acc_q       <= '0;
         a_out_q     <= '0;
         b_out_q     <= '0;
         v_out_q     <= 1'b0;
         acc_out_q   <= '0;
         res_valid_q <= 1'b0;
         pdone_q     <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         acc_q       <= acc_d;
         a_out_q     <= a_out_d;
         b_out_q     <= b_out_d;
         v_out_q     <= v_out_d;
         acc_out_q   <= acc_out_d;
         res_valid_q <= res_valid_d;
         pdone_q     <= pdone_d;
         ovf_q       <= ovf_d;
      end
   end

   assign a_out     = a_out_q;
   assign b_out     = b_out_q;
   assign v_out     = v_out_q;
   assign acc_out   = acc_out_q;
   assign res_valid = res_valid_q;
   assign pdone     = pdone_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_systolic_pe.sv
// Self-checking bench for systolic_pe: an unsigned and a signed instance share
// stimulus and are compared against a beat-queue reference model.
module tb_systolic_pe;

   localparam int DW   = 8;
   localparam int N    = 2;
   localparam int ACCW = 17;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic [DW-1:0]   a_in;
   logic [DW-1:0]   b_in;
   logic            clr;
   logic            res_ready;

   logic [DW-1:0]   a_out_u,     a_out_s;
   logic [DW-1:0]   b_out_u,     b_out_s;
   logic            v_out_u,     v_out_s;
   logic [ACCW-1:0] acc_out_u,   acc_out_s;
   logic            res_valid_u, res_valid_s;
   logic            pdone_u,     pdone_s;
   logic            ovf_u,       ovf_s;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   systolic_pe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a_in      (a_in),
      .b_in      (b_in),
      .clr       (clr),
      .res_ready (res_ready),
      .a_out     (a_out_u),
      .b_out     (b_out_u),
      .v_out     (v_out_u),
      .acc_out   (acc_out_u),
      .res_valid (res_valid_u),
      .pdone     (pdone_u),
      .ovf       (ovf_u)
   );

   systolic_pe #(.DW(DW), .N(N), .SIGNED(1'b1)) dut_s (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a_in      (a_in),
      .b_in      (b_in),
      .clr       (clr),
      .res_ready (res_ready),
      .a_out     (a_out_s),
      .b_out     (b_out_s),
      .v_out     (v_out_s),
      .acc_out   (acc_out_s),
      .res_valid (res_valid_s),
      .pdone     (pdone_s),
      .ovf       (ovf_s)
   );

   // Reference model: pending beats are kept as a list; a result is the
   // modular sum of the products of N collected beats.
   logic [DW-1:0]   pend_a[$];
   logic [DW-1:0]   pend_b[$];
   logic [DW-1:0]   exp_a, exp_b;
   logic            exp_v, exp_rv, exp_pd, exp_ovf;
   logic [ACCW-1:0] exp_acc_u, exp_acc_s;

   function automatic logic [ACCW-1:0] sum_products(input bit sgn);
      longint total = 0;
      for (int i = 0; i < pend_a.size(); i++) begin
         if (sgn) total += longint'($signed(pend_a[i])) * longint'($signed(pend_b[i]));
         else     total += longint'(pend_a[i]) * longint'(pend_b[i]);
      end
      return ACCW'(total);
   endfunction

   task automatic model_edge();
      bit finished = 0;
      if (!rst) begin
         pend_a.delete(); pend_b.delete();
         exp_a = '0; exp_b = '0; exp_v = 0;
         exp_rv = 0; exp_pd = 0; exp_ovf = 0;
         exp_acc_u = '0; exp_acc_s = '0;
         return;
      end
      exp_a = a_in; exp_b = b_in; exp_v = in_valid;
      if (clr) begin
         pend_a.delete(); pend_b.delete();
      end
      if (in_valid) begin
         pend_a.push_back(a_in);
         pend_b.push_back(b_in);
         if (pend_a.size() == N) begin
            finished = 1;
            if (exp_rv && !res_ready) exp_ovf = 1;
            exp_acc_u = sum_products(0);
            exp_acc_s = sum_products(1);
            pend_a.delete(); pend_b.delete();
         end
      end
      if (finished)                exp_rv = 1;
      else if (exp_rv && res_ready) exp_rv = 0;
      exp_pd = finished;
   endtask

   // One clock: inputs are sampled at the edge, outputs are stable 1ns later.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic beat(input logic [DW-1:0] a, input logic [DW-1:0] b);
      in_valid = 1; a_in = a; b_in = b;
      cycle();
      in_valid = 0;
   endtask

   task automatic do_reset();
      rst = 0;
      cycle();
      rst = 1;
   endtask

   task automatic test_reset();
      logic [2*DW+1+2*ACCW+6:0] obs;
      rst = 0; in_valid = 1; clr = 1; res_ready = 1;
      for (int i = 0; i < 3; i++) begin
         a_in = DW'($urandom); b_in = DW'($urandom); res_ready = 1'($urandom);
         cycle();
         obs = {a_out_u, b_out_u, v_out_u, acc_out_u, acc_out_s,
                res_valid_u, pdone_u, ovf_u, res_valid_s, pdone_s, ovf_s, v_out_s};
         n_vec++;
         if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_state: got %h, want 0", obs);
         end
      end
      rst = 1; in_valid = 0; clr = 0; res_ready = 0;
   endtask

   task automatic test_basic();
      beat(8'd3, 8'd4);
      n_vec++;
      if (pdone_u !== 1'b0 || res_valid_u !== 1'b0) begin
         n_err++;
         $display("FAIL basic_first_beat: pdone=%b res_valid=%b, want 0 0", pdone_u, res_valid_u);
      end
      beat(8'd5, 8'd6);
      n_vec++;
      if (acc_out_u !== 17'd42 || pdone_u !== 1'b1 || res_valid_u !== 1'b1) begin
         n_err++;
         $display("FAIL basic_result: acc=%0d pdone=%b rv=%b, want 42 1 1", acc_out_u, pdone_u, res_valid_u);
      end
      cycle();
      n_vec++;
      if (pdone_u !== 1'b0 || res_valid_u !== 1'b1 || acc_out_u !== 17'd42) begin
         n_err++;
         $display("FAIL basic_hold: acc=%0d pdone=%b rv=%b, want 42 0 1", acc_out_u, pdone_u, res_valid_u);
      end
      res_ready = 1;
      cycle();
      res_ready = 0;
      n_vec++;
      if (res_valid_u !== 1'b0 || ovf_u !== 1'b0) begin
         n_err++;
         $display("FAIL basic_consume: rv=%b ovf=%b, want 0 0", res_valid_u, ovf_u);
      end
   endtask

   task automatic test_signed();
      res_ready = 1;
      beat(8'h80, 8'h80);
      beat(8'hFF, 8'h02);
      n_vec++;
      if (acc_out_s !== 17'd16382) begin
         n_err++;
         $display("FAIL signed_sum: got %0d, want 16382", acc_out_s);
      end
      n_vec++;
      if (acc_out_u !== 17'd16894) begin
         n_err++;
         $display("FAIL unsigned_sum: got %0d, want 16894", acc_out_u);
      end
      cycle();
      res_ready = 0;
   endtask

   task automatic test_overflow();
      do_reset();
      res_ready = 0;
      beat(8'd1, 8'd1);
      beat(8'd1, 8'd1);
      n_vec++;
      if (acc_out_u !== 17'd2 || ovf_u !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_first: acc=%0d ovf=%b, want 2 0", acc_out_u, ovf_u);
      end
      beat(8'd2, 8'd2);
      beat(8'd2, 8'd2);
      n_vec++;
      if (acc_out_u !== 17'd8 || ovf_u !== 1'b1 || res_valid_u !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_overwrite: acc=%0d ovf=%b rv=%b, want 8 1 1", acc_out_u, ovf_u, res_valid_u);
      end
      res_ready = 1;
      cycle();
      res_ready = 0;
      cycle();
      n_vec++;
      if (res_valid_u !== 1'b0 || ovf_u !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_sticky: rv=%b ovf=%b, want 0 1", res_valid_u, ovf_u);
      end
   endtask

   task automatic test_clr();
      logic [DW-1:0] a_seq[3] = '{8'd7, 8'd1, 8'd3};
      logic [DW-1:0] b_seq[3] = '{8'd7, 8'd2, 8'd3};
      do_reset();
      res_ready = 1;
      for (int i = 0; i < 3; i++) begin
         clr = (i == 1);
         in_valid = 1; a_in = a_seq[i]; b_in = b_seq[i];
         cycle();
         clr = 0;
         n_vec++;
         if (a_out_u !== a_seq[i] || b_out_u !== b_seq[i] || v_out_u !== 1'b1) begin
            n_err++;
            $display("FAIL clr_forward[%0d]: a=%0d b=%0d v=%b, want %0d %0d 1",
                     i, a_out_u, b_out_u, v_out_u, a_seq[i], b_seq[i]);
         end
         n_vec++;
         if (pdone_u !== (i == 2)) begin
            n_err++;
            $display("FAIL clr_pdone[%0d]: got %b, want %b", i, pdone_u, (i == 2));
         end
      end
      in_valid = 0;
      n_vec++;
      if (acc_out_u !== 17'd11) begin
         n_err++;
         $display("FAIL clr_result: got %0d, want 11", acc_out_u);
      end
      cycle();
      n_vec++;
      if (v_out_u !== 1'b0 || res_valid_u !== 1'b0) begin
         n_err++;
         $display("FAIL clr_idle: v=%b rv=%b, want 0 0", v_out_u, res_valid_u);
      end
   endtask

   task automatic test_reset_mid();
      res_ready = 0;
      beat(8'd9, 8'd9);
      rst = 0; in_valid = 1; clr = 0; a_in = 8'd5; b_in = 8'd5; res_ready = 1;
      cycle();
      n_vec++;
      if ({a_out_u, b_out_u, v_out_u, acc_out_u, res_valid_u, pdone_u, ovf_u} !== '0) begin
         n_err++;
         $display("FAIL midreset_zero: a=%0d b=%0d v=%b acc=%0d rv=%b pd=%b ovf=%b",
                  a_out_u, b_out_u, v_out_u, acc_out_u, res_valid_u, pdone_u, ovf_u);
      end
      rst = 1; in_valid = 0; res_ready = 0;
      beat(8'd2, 8'd3);
      n_vec++;
      if (pdone_u !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_partial: pdone=%b, want 0", pdone_u);
      end
      beat(8'd4, 8'd5);
      n_vec++;
      if (acc_out_u !== 17'd26 || pdone_u !== 1'b1) begin
         n_err++;
         $display("FAIL midreset_result: acc=%0d pdone=%b, want 26 1", acc_out_u, pdone_u);
      end
   endtask

   task automatic test_back_to_back();
      logic [2*DW+2*ACCW+3:0] obs, exp;
      do_reset();
      for (int i = 0; i < 200; i++) begin
         if (i < 20) begin
            in_valid = 1; clr = 0; res_ready = 1;
         end else begin
            in_valid  = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 9) == 0);
            res_ready = 1'($urandom);
         end
         a_in = DW'($urandom);
         b_in = DW'($urandom);
         cycle();
         obs = {a_out_u, b_out_u, v_out_u, acc_out_u, acc_out_s, res_valid_u, pdone_u, ovf_u};
         exp = {exp_a,   exp_b,   exp_v,   exp_acc_u, exp_acc_s, exp_rv,      exp_pd,  exp_ovf};
         n_vec++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL random[%0d]: got a=%0d b=%0d v=%b accu=%0d accs=%0d rv=%b pd=%b ovf=%b, want a=%0d b=%0d v=%b accu=%0d accs=%0d rv=%b pd=%b ovf=%b",
                     i, a_out_u, b_out_u, v_out_u, acc_out_u, acc_out_s, res_valid_u, pdone_u, ovf_u,
                     exp_a, exp_b, exp_v, exp_acc_u, exp_acc_s, exp_rv, exp_pd, exp_ovf);
         end
      end
      in_valid = 0; clr = 0; res_ready = 0;
   endtask

   initial begin
      rst = 0; in_valid = 0; clr = 0; res_ready = 0; a_in = '0; b_in = '0;
      test_reset();
      test_basic();
      test_signed();
      test_overflow();
      test_clr();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
